plic_irq_arb_pipe: RTL

Pipelined, parametrised successor to the combinational PLIC priority arbiter. It selects the highest-priority enabled pending source among `NUM_IRQ` inputs through a comparator tree with configurable register insertion. It applies a per-target priority threshold and optionally tracks claim/complete so that an in-service source cannot win again. It sits between the gateway/pending array and one target's notification/claim register.

---
 rtl/plic_irq_arb_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/plic_irq_arb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : plic_irq_arb_pipe
// Purpose  : Pipelined PLIC priority arbiter for one target. Picks the
//            highest-priority enabled pending source through a binary
//            comparator tree with a register after every REG_EVERY levels,
//            gates the result with the target threshold and (optionally)
//            tracks claim/complete so an in-service source cannot win again.
// Options  : PLIC_ARB_CLAIM_EN - when defined, in-service tracking and the
//            claim/complete interface are built; otherwise claim_i,
//            complete_i and complete_id_i are ignored and claim_id_o is 0.
// Ports    : clk, rst_n (async, active low)
//            irq_i / irq_en_i / irq_pri_i : per-source pending, enable, prio
//            thresh_i                     : target threshold (strictly above)
//            claim_i, complete_i, complete_id_i : claim/complete strobes
//            irq_o, irq_id_o, irq_pri_o   : notification, winning ID/prio
//            claim_id_o                   : ID returned by the last claim
// Revision : 1.0 - initial release
// ============================================================================
module plic_irq_arb_pipe #(
    parameter int NUM_IRQ   = 32,
    parameter int ID_BASE   = 32,
    parameter int PRIO_BIT  = 5,
    parameter int ID_WIDTH  = 6,
    parameter int REG_EVERY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  irq_en_i,
    input  logic [PRIO_BIT-1:0] irq_pri_i [NUM_IRQ],
    input  logic [PRIO_BIT-1:0] thresh_i,
    input  logic                claim_i,
    input  logic                complete_i,
    input  logic [ID_WIDTH-1:0] complete_id_i,
    output logic                irq_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    output logic [PRIO_BIT-1:0] irq_pri_o,
    output logic [ID_WIDTH-1:0] claim_id_o
);

    localparam int LVLS    = $clog2(NUM_IRQ);
    localparam int P       = 1 << LVLS;
    localparam int IDX_W   = (LVLS > 0) ? LVLS : 1;
    localparam int PS      = 1 << IDX_W;
    localparam int NODES   = 2 * P - 1;
    localparam int RE_SAFE = (REG_EVERY < 1) ? 1 : REG_EVERY;

    if (REG_EVERY < 1) begin : g_err_reg_every
        $error("plic_irq_arb_pipe: REG_EVERY must be >= 1");
    end
    if ((NUM_IRQ < 1) || (NUM_IRQ > 1024)) begin : g_err_num_irq
        $error("plic_irq_arb_pipe: NUM_IRQ must be 1..1024");
    end
    if ((ID_BASE + NUM_IRQ - 1) > ((2 ** ID_WIDTH) - 1)) begin : g_err_id_width
        $error("plic_irq_arb_pipe: ID_WIDTH too small for ID_BASE+NUM_IRQ-1");
    end

    typedef struct packed {
        logic                vld;
        logic [IDX_W-1:0]    idx;
        logic [PRIO_BIT-1:0] pri;
    } node_t;

    // Heap-ordered tree: node 0 is the root, children of j are 2j+1 / 2j+2,
    // leaves occupy P-1 .. 2P-2. w_node_c is the node's own compare result,
    // w_node_q is what its parent sees (registered or pass-through).
    node_t              w_node_c [NODES];
    node_t              w_node_q [NODES];
    node_t              r_res;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [PS-1:0]      w_svc_pad;
    logic               w_hit;

    for (genvar j = 0; j < NODES; j++) begin : g_node
        localparam int DEPTH = $clog2(j + 2) - 1;
        localparam int LEVEL = LVLS - DEPTH;

        if (j >= P - 1) begin : g_leaf
            localparam int SRC = j - (P - 1);
            if (SRC < NUM_IRQ) begin : g_real
                // An in-service source is masked here so it drops out of
                // every arbitration started after its claim edge.
                assign w_node_c[j] = {irq_i[SRC] & irq_en_i[SRC]
                                      & (irq_pri_i[SRC] != '0)
                                      & ~r_in_service[SRC],
                                      IDX_W'(SRC), irq_pri_i[SRC]};
            end else begin : g_pad
                assign w_node_c[j] = '0;
            end
        end else begin : g_cmp
            node_t w_l;
            node_t w_r;
            assign w_l = w_node_q[2*j+1];
            assign w_r = w_node_q[2*j+2];
            // Left child carries the lower indices, so it wins ties.
            assign w_node_c[j] = (w_r.vld && (!w_l.vld || (w_r.pri > w_l.pri)))
                                 ? w_r : w_l;
        end

        if ((LEVEL > 0) && (LEVEL < LVLS) && ((LEVEL % RE_SAFE) == 0)) begin : g_reg
            node_t r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_node_c[j];
                end
            end
            assign w_node_q[j] = r_q;
        end else begin : g_comb
            assign w_node_q[j] = w_node_c[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else begin
            r_res <= w_node_q[0];
        end
    end

    // Second in-service check catches results already in flight when the
    // source was claimed.
    always_comb begin
        w_svc_pad                = '0;
        w_svc_pad[NUM_IRQ-1:0]   = r_in_service;
    end

    assign w_hit     = r_res.vld && (r_res.pri > thresh_i) && !w_svc_pad[r_res.idx];
    assign irq_o     = w_hit;
    assign irq_id_o  = w_hit ? (ID_WIDTH'(ID_BASE) + ID_WIDTH'(r_res.idx)) : '0;
    assign irq_pri_o = w_hit ? r_res.pri : '0;

`ifdef PLIC_ARB_CLAIM_EN
    logic [31:0]        w_cidx;
    logic               w_cmp_ok;
    logic [NUM_IRQ-1:0] w_svc_nxt;

    always_comb begin
        w_cidx    = 32'(complete_id_i) - 32'(ID_BASE);
        w_cmp_ok  = complete_i && (32'(complete_id_i) >= 32'(ID_BASE))
                    && (w_cidx < 32'(NUM_IRQ));
        w_svc_nxt = r_in_service;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_cmp_ok && (w_cidx == 32'(i))) begin
                w_svc_nxt[i] = 1'b0;
            end
            // Applied after the clear so a same-cycle claim wins.
            if (claim_i && w_hit && (32'(r_res.idx) == 32'(i))) begin
                w_svc_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_service <= '0;
            claim_id_o   <= '0;
        end else begin
            r_in_service <= w_svc_nxt;
            if (claim_i) begin
                claim_id_o <= irq_id_o;   // already 0 when there is no hit
            end
        end
    end
`else
    logic unused_claim;
    assign r_in_service = '0;
    assign claim_id_o   = '0;
    assign unused_claim = ^{claim_i, complete_i, complete_id_i};
`endif

endmodule
`default_nettype wire
